// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration chain loader: byte width,
// FSM state encoding and a helper for left-aligning partial readback bytes.
package config_loader_pkg;

    localparam int CFG_BYTE_W = 8;
    localparam int BIT_IDX_W  = $clog2(CFG_BYTE_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

    // Moves a byte whose newest bit sits at position 0 up so that bit
    // last_idx lands at the MSB; the vacated low bits become zero.
    function automatic logic [CFG_BYTE_W-1:0] left_align(
        input logic [CFG_BYTE_W-1:0] bits,
        input logic [BIT_IDX_W-1:0]  last_idx
    );
        logic [BIT_IDX_W-1:0] sh;
        sh = BIT_IDX_W'(CFG_BYTE_W - 1) - last_idx;
        return bits << sh;
    endfunction

endpackage

// File: rtl/cfg_readback_deser.sv
// Readback deserializer: collects tail bits MSB-first (LSB-in shifting),
// emits a byte with a one-cycle valid after every 8 bits, and on flush
// emits any partial byte left-aligned with zero low bits.
module cfg_readback_deser
    import config_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic                  tail_bit,
    input  logic                  flush,
    output logic [CFG_BYTE_W-1:0] rb_data,
    output logic                  rb_valid
);

    logic [CFG_BYTE_W-1:0] sr;
    logic [CFG_BYTE_W-1:0] sr_next;
    logic [BIT_IDX_W-1:0]  cnt;
    logic                  byte_full;

    assign sr_next   = {sr[CFG_BYTE_W-2:0], tail_bit};
    assign byte_full = (cnt == BIT_IDX_W'(CFG_BYTE_W - 1));

    // Shift in sampled bits; publish a byte when full or at session end.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            cnt      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (sample_en) begin
                if (byte_full || flush) begin
                    rb_data  <= left_align(sr_next, cnt);
                    rb_valid <= 1'b1;
                    sr       <= '0;
                    cnt      <= '0;
                end else begin
                    sr  <= sr_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/config_chain_loader.sv
// Configuration chain loader: pulls bitstream bytes over a valid/ready
// port and shifts them MSB-first into a ccff chain of CHAIN_LEN bits,
// while deserializing the bits leaving the chain tail for readback.
//
// Handshake: a byte transfers on a rising edge where cfg_valid and
// cfg_ready are both 1; cfg_ready is high only in FETCH and does not
// depend on cfg_valid, so the source may hold cfg_valid as long as it likes.
module config_chain_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  start,
    input  logic [CFG_BYTE_W-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  chain_shift_en,
    input  logic                  ccff_tail,
    output logic [CFG_BYTE_W-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done,
    output loader_state_e         dbg_state
);

    loader_state_e         state;
    loader_state_e         state_next;
    logic [CFG_BYTE_W-1:0] shreg;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  done_q;
    logic                  last_bit;
    logic                  byte_end;
    logic                  session_end;

    // The chain is full when the bit now on ccff_head is number CHAIN_LEN.
    assign last_bit    = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign byte_end    = (bit_idx == BIT_IDX_W'(CFG_BYTE_W - 1));
    assign session_end = (state == SHIFT) && last_bit;
    assign done        = done_q;
    assign dbg_state   = state;

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; the head bit is forced low off-shift.
    always_comb begin
        state_next     = state;
        cfg_ready      = 1'b0;
        chain_shift_en = 1'b0;
        ccff_head      = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy           = 1'b1;
                chain_shift_en = 1'b1;
                ccff_head      = shreg[CFG_BYTE_W-1];
                if (last_bit) begin
                    state_next = DONE;
                end else if (byte_end) begin
                    state_next = FETCH;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: byte latch, bit counters and the sticky done flag.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shreg   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        done_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        shreg   <= cfg_data;
                        bit_idx <= '0;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[CFG_BYTE_W-2:0], 1'b0};
                    bit_idx <= bit_idx + 1'b1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    cfg_readback_deser u_readback (
        .clk       (prog_clk),
        .rst       (prog_reset),
        .sample_en (chain_shift_en),
        .tail_bit  (ccff_tail),
        .flush     (session_end),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid)
    );

endmodule
